// File: rtl/vsetvl_if.sv
// Instruction-side handshake plus CSR write port and rd writeback of the vsetvl unit.
interface vsetvl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] cur_vl;
    logic        vconfig_wr_en;
    logic [31:0] vl_in;
    logic [31:0] vtype_in;
    logic        rd_wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;

    // Unit side: consumes the instruction, produces CSR and writeback traffic.
    modport slave (
        input  instr_valid, instr, rs1_data, rs2_data, cur_vl,
        output instr_ready, vconfig_wr_en, vl_in, vtype_in,
        output rd_wr_en, rd_addr, rd_data, busy
    );

    // Issue side: presents instructions, observes the results.
    modport master (
        output instr_valid, instr, rs1_data, rs2_data, cur_vl,
        input  instr_ready, vconfig_wr_en, vl_in, vtype_in,
        input  rd_wr_en, rd_addr, rd_data, busy
    );
endinterface

// File: rtl/vsetvl_unit.sv
// RVV configuration-instruction unit: decodes vsetvli/vsetivli/vsetvl, resolves
// AVL and vtype, computes VLMAX and the new vl, then writes the vector CSR and rd.
// Flow is IDLE -> CALC -> WRITE -> IDLE, one instruction every three cycles.
module vsetvl_unit #(
    parameter int VLEN = 128,
    parameter int ELEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    vsetvl_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_CALC  = 2'b01;
    localparam logic [1:0] S_WRITE = 2'b10;

    localparam logic [6:0] OPC_V    = 7'b1010111;
    localparam logic [2:0] F3_CFG   = 3'b111;
    localparam logic [31:0] VILL_VT = 32'h8000_0000;

    logic [1:0]  state_q, state_d;
    logic [31:0] vtype_q, vtype_d;
    logic [31:0] avl_q, avl_d;
    logic [4:0]  rd_q, rd_d;
    logic        vill_q, vill_d;
    logic [31:0] vlmax_q, vlmax_d;
    logic [31:0] vl_out_q, vl_out_d;
    logic [31:0] vtype_out_q, vtype_out_d;
    logic [4:0]  rd_out_q, rd_out_d;

    logic        is_vsetvli, is_vsetivli, is_vsetvl, is_cfg, accept;
    logic [4:0]  dec_rs1, dec_rd;
    logic [31:0] dec_vtype, dec_avl;
    logic [2:0]  vsew, vlmul;
    logic [31:0] sew, vlen_per_sew, vlmax_calc;
    logic        vill_calc;
    logic [31:0] vl_now, vtype_now;

    // Decode the presented word and resolve vtype and AVL at acceptance time.
    always_comb begin
        dec_rs1     = bus.instr[19:15];
        dec_rd      = bus.instr[11:7];
        is_vsetvli  = (bus.instr[31] == 1'b0);
        is_vsetivli = (bus.instr[31:30] == 2'b11);
        is_vsetvl   = (bus.instr[31:25] == 7'b1000000);
        is_cfg      = (bus.instr[6:0] == OPC_V) && (bus.instr[14:12] == F3_CFG) &&
                      (is_vsetvli || is_vsetivli || is_vsetvl);

        if (is_vsetivli)    dec_vtype = {22'b0, bus.instr[29:20]};
        else if (is_vsetvl) dec_vtype = bus.rs2_data;
        else                dec_vtype = {21'b0, bus.instr[30:20]};

        // rs1=x0 with rd!=x0 requests the maximum vl; with rd=x0 it keeps the current vl.
        if (is_vsetivli)        dec_avl = {27'b0, dec_rs1};
        else if (dec_rs1 != 0)  dec_avl = bus.rs1_data;
        else if (dec_rd != 0)   dec_avl = 32'hFFFF_FFFF;
        else                    dec_avl = bus.cur_vl;

        accept = bus.instr_valid && (state_q == S_IDLE) && is_cfg;
    end

    // Evaluate SEW, legality and VLMAX from the latched vtype.
    always_comb begin
        vsew         = vtype_q[5:3];
        vlmul        = vtype_q[2:0];
        sew          = 32'd8 << vsew;
        vlen_per_sew = 32'(VLEN) >> ({1'b0, vsew} + 4'd3);
        if (vlmul[2] == 1'b0) vlmax_calc = vlen_per_sew << vlmul;
        else                  vlmax_calc = vlen_per_sew >> (4'd8 - {1'b0, vlmul});
        vill_calc = (vsew[2] == 1'b1) || (sew > 32'(ELEN)) || (vlmul == 3'b100) ||
                    (vtype_q[31:8] != 24'b0) || (vlmax_calc == 32'b0);
    end

    // Result of the WRITE cycle: clipped vl and the vtype actually committed.
    always_comb begin
        vl_now    = vill_q ? 32'b0 : ((avl_q < vlmax_q) ? avl_q : vlmax_q);
        vtype_now = vill_q ? VILL_VT : {24'b0, vtype_q[7:0]};
    end

    // Next-state and next-value logic for every flop.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        vtype_d     = vtype_q;
        avl_d       = avl_q;
        rd_d        = rd_q;
        vill_d      = vill_q;
        vlmax_d     = vlmax_q;
        vl_out_d    = vl_out_q;
        vtype_out_d = vtype_out_q;
        rd_out_d    = rd_out_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    vtype_d = dec_vtype;
                    avl_d   = dec_avl;
                    rd_d    = dec_rd;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                vill_d  = vill_calc;
                vlmax_d = vlmax_calc;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                vl_out_d    = vl_now;
                vtype_out_d = vtype_now;
                rd_out_d    = rd_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset drops any in-flight instruction.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            vtype_q     <= '0;
            avl_q       <= '0;
            rd_q        <= '0;
            vill_q      <= 1'b0;
            vlmax_q     <= '0;
            vl_out_q    <= '0;
            vtype_out_q <= '0;
            rd_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            vtype_q     <= vtype_d;
            avl_q       <= avl_d;
            rd_q        <= rd_d;
            vill_q      <= vill_d;
            vlmax_q     <= vlmax_d;
            vl_out_q    <= vl_out_d;
            vtype_out_q <= vtype_out_d;
            rd_out_q    <= rd_out_d;
        end
    end

    // Outputs: live values during WRITE, last committed values otherwise.
    always_comb begin
        bus.instr_ready   = (state_q == S_IDLE);
        bus.busy          = (state_q != S_IDLE);
        bus.vconfig_wr_en = (state_q == S_WRITE);
        bus.rd_wr_en      = (state_q == S_WRITE) && (rd_q != 5'd0);
        bus.vl_in         = (state_q == S_WRITE) ? vl_now    : vl_out_q;
        bus.vtype_in      = (state_q == S_WRITE) ? vtype_now : vtype_out_q;
        bus.rd_addr       = (state_q == S_WRITE) ? rd_q      : rd_out_q;
        bus.rd_data       = bus.vl_in;
    end

endmodule

// File: tb/tb_vsetvl_unit.sv
// Directed bench for vsetvl_unit with VLEN=128, ELEN=32.
module tb_vsetvl_unit;

    localparam logic [6:0] OPC = 7'b1010111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulse_cnt = 0;
    int   pulse_base;

    vsetvl_if vif ();

    vsetvl_unit #(.VLEN(128), .ELEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    always #5 clk = ~clk;

    // Count CSR write strobes seen on rising edges.
    always @(posedge clk) if (vif.vconfig_wr_en === 1'b1) pulse_cnt <= pulse_cnt + 1;

    function automatic logic [31:0] enc_vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                                input logic [10:0] zimm);
        return {1'b0, zimm, rs1, 3'b111, rd, OPC};
    endfunction

    function automatic logic [31:0] enc_vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                                 input logic [9:0] zimm);
        return {2'b11, zimm, uimm, 3'b111, rd, OPC};
    endfunction

    function automatic logic [31:0] enc_vsetvl(input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2);
        return {7'b1000000, rs2, rs1, 3'b111, rd, OPC};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one config instruction from IDLE and check the full three-cycle flow.
    task automatic run_cfg(input string tag, input logic [31:0] w, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] cv,
                           input logic [31:0] exp_vl, input logic [31:0] exp_vt,
                           input logic exp_rdw, input logic [4:0] exp_rd);
        check({tag, ".ready"}, 32'(vif.instr_ready), 32'd1);
        vif.instr       = w;
        vif.rs1_data    = r1;
        vif.rs2_data    = r2;
        vif.cur_vl      = cv;
        vif.instr_valid = 1'b1;
        step();
        vif.instr_valid = 1'b0;
        vif.rs1_data    = 32'hDEAD_BEEF;
        vif.rs2_data    = 32'hDEAD_BEEF;
        vif.cur_vl      = 32'hDEAD_BEEF;
        check({tag, ".calc_busy"}, 32'(vif.busy), 32'd1);
        check({tag, ".calc_wr"}, 32'(vif.vconfig_wr_en), 32'd0);
        step();
        check({tag, ".wr_en"}, 32'(vif.vconfig_wr_en), 32'd1);
        check({tag, ".vl_in"}, vif.vl_in, exp_vl);
        check({tag, ".vtype_in"}, vif.vtype_in, exp_vt);
        check({tag, ".rd_wr_en"}, 32'(vif.rd_wr_en), 32'(exp_rdw));
        check({tag, ".rd_addr"}, 32'(vif.rd_addr), 32'(exp_rd));
        check({tag, ".rd_data"}, vif.rd_data, exp_vl);
        step();
        check({tag, ".idle_wr"}, 32'(vif.vconfig_wr_en), 32'd0);
        check({tag, ".idle_ready"}, 32'(vif.instr_ready), 32'd1);
        check({tag, ".hold_vl"}, vif.vl_in, exp_vl);
    endtask

    initial begin
        vif.instr_valid = 1'b0;
        vif.instr       = '0;
        vif.rs1_data    = '0;
        vif.rs2_data    = '0;
        vif.cur_vl      = '0;

        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst.ready", 32'(vif.instr_ready), 32'd1);
        check("rst.busy", 32'(vif.busy), 32'd0);
        check("rst.wr_en", 32'(vif.vconfig_wr_en), 32'd0);
        check("rst.rd_wr_en", 32'(vif.rd_wr_en), 32'd0);
        check("rst.vl_in", vif.vl_in, 32'd0);
        check("rst.vtype_in", vif.vtype_in, 32'd0);
        check("rst.rd_addr", 32'(vif.rd_addr), 32'd0);
        check("rst.rd_data", vif.rd_data, 32'd0);

        // vsetvli x1,x5,e32,m1, AVL=10 -> VLMAX=4
        run_cfg("vli_e32m1", enc_vsetvli(5'd1, 5'd5, 11'h010), 32'd10, 32'd0, 32'd0,
                32'd4, 32'h10, 1'b1, 5'd1);
        // vsetivli x2,3,e8,m2 -> VLMAX=32, vl=3
        run_cfg("vili_e8m2", enc_vsetivli(5'd2, 5'd3, 10'h001), 32'd0, 32'd0, 32'd0,
                32'd3, 32'h01, 1'b1, 5'd2);
        // vsetvl x3,x6,x7 with vlmul=100 -> vill
        run_cfg("vl_resv_lmul", enc_vsetvl(5'd3, 5'd6, 5'd7), 32'd5, 32'h04, 32'd0,
                32'd0, 32'h8000_0000, 1'b1, 5'd3);
        // vsetvli x1,x0,e16,m8 -> AVL=max, vl=VLMAX=64
        run_cfg("vli_e16m8", enc_vsetvli(5'd1, 5'd0, 11'h00B), 32'd99, 32'd0, 32'd0,
                32'd64, 32'h0B, 1'b1, 5'd1);
        // vsetvli x0,x0,e16,mf2 with cur_vl=64 -> VLMAX=4, no rd write
        run_cfg("vli_keep_vl", enc_vsetvli(5'd0, 5'd0, 11'h00F), 32'd0, 32'd0, 32'd64,
                32'd4, 32'h0F, 1'b0, 5'd0);
        // e64 exceeds ELEN=32 -> vill
        run_cfg("vli_sew_gt_elen", enc_vsetvli(5'd4, 5'd5, 11'h018), 32'd3, 32'd0, 32'd0,
                32'd0, 32'h8000_0000, 1'b1, 5'd4);
        // e32,mf8 gives VLMAX=0 -> vill
        run_cfg("vili_vlmax0", enc_vsetivli(5'd6, 5'd1, 10'h015), 32'd0, 32'd0, 32'd0,
                32'd0, 32'h8000_0000, 1'b1, 5'd6);
        // e8,mf8 gives VLMAX=2, AVL=31 clipped to 2
        run_cfg("vili_e8mf8", enc_vsetivli(5'd5, 5'd31, 10'h005), 32'd0, 32'd0, 32'd0,
                32'd2, 32'h05, 1'b1, 5'd5);
        // Nonzero vtype[31:8] -> vill
        run_cfg("vli_hi_bits", enc_vsetvli(5'd7, 5'd8, 11'h110), 32'd9, 32'd0, 32'd0,
                32'd0, 32'h8000_0000, 1'b1, 5'd7);

        // Back-to-back with instr_valid held high
        pulse_base      = pulse_cnt;
        vif.instr       = enc_vsetvli(5'd1, 5'd5, 11'h010);
        vif.rs1_data    = 32'd10;
        vif.instr_valid = 1'b1;
        step();
        check("b2b.ready_calc", 32'(vif.instr_ready), 32'd0);
        vif.instr = enc_vsetivli(5'd2, 5'd3, 10'h001);
        step();
        check("b2b.ready_write", 32'(vif.instr_ready), 32'd0);
        check("b2b.first_vl", vif.vl_in, 32'd4);
        step();
        check("b2b.ready_idle", 32'(vif.instr_ready), 32'd1);
        check("b2b.idle_wr", 32'(vif.vconfig_wr_en), 32'd0);
        step();
        vif.instr_valid = 1'b0;
        check("b2b.second_busy", 32'(vif.busy), 32'd1);
        step();
        check("b2b.second_wr", 32'(vif.vconfig_wr_en), 32'd1);
        check("b2b.second_vl", vif.vl_in, 32'd3);
        step();
        check("b2b.pulses", 32'(pulse_cnt - pulse_base), 32'd2);

        // Reset asserted during CALC
        pulse_base      = pulse_cnt;
        vif.instr       = enc_vsetvli(5'd1, 5'd5, 11'h010);
        vif.rs1_data    = 32'd10;
        vif.instr_valid = 1'b1;
        step();
        vif.instr_valid = 1'b0;
        rst = 1'b1;
        check("rstcalc.busy_before", 32'(vif.busy), 32'd1);
        step();
        rst = 1'b0;
        check("rstcalc.ready", 32'(vif.instr_ready), 32'd1);
        check("rstcalc.busy", 32'(vif.busy), 32'd0);
        check("rstcalc.wr_en", 32'(vif.vconfig_wr_en), 32'd0);
        check("rstcalc.vl_in", vif.vl_in, 32'd0);
        step();
        step();
        check("rstcalc.no_pulse", 32'(pulse_cnt - pulse_base), 32'd0);

        // Reset together with a valid config instruction: nothing accepted
        vif.instr_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vif.instr_valid = 1'b0;
        check("rstvalid.busy", 32'(vif.busy), 32'd0);
        step();
        check("rstvalid.busy2", 32'(vif.busy), 32'd0);

        // Non-config words are never accepted
        pulse_base      = pulse_cnt;
        vif.instr       = 32'h0020_81B3;
        vif.instr_valid = 1'b1;
        step();
        check("nonv.busy1", 32'(vif.busy), 32'd0);
        step();
        check("nonv.busy2", 32'(vif.busy), 32'd0);
        check("nonv.ready", 32'(vif.instr_ready), 32'd1);
        vif.instr = {7'b1000001, 5'd7, 5'd6, 3'b111, 5'd3, OPC};
        step();
        check("badcfg.busy1", 32'(vif.busy), 32'd0);
        step();
        check("badcfg.busy2", 32'(vif.busy), 32'd0);
        vif.instr_valid = 1'b0;
        step();
        check("nonv.no_pulse", 32'(pulse_cnt - pulse_base), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
